// File: rtl/branch_squash_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_squash_ctrl_pkg
// Shared core types for branch writeback / squash handling.
//   robIdx_t        : {flag, index}; flag toggles on every ROB wrap
//   ftqIdx_t        : fetch target queue entry index
//   branchWBInfo_t  : payload a BRU writes back for a resolved branch
//   squashInfo_t    : payload broadcast to fetch, FTQ and rename on a squash
//   older()         : ROB age compare, also used by the ROB and LSQ
// ---------------------------------------------------------------------------
package branch_squash_ctrl_pkg;

   localparam int unsigned ROB_IDX_W = 6;   // 64-entry ROB
   localparam int unsigned FTQ_IDX_W = 5;   // 32-entry FTQ
   localparam int unsigned PC_W      = 32;

   typedef struct packed {
      logic                 flag;
      logic [ROB_IDX_W-1:0] index;
   } robIdx_t;

   typedef logic [FTQ_IDX_W-1:0] ftqIdx_t;

   typedef struct packed {
      robIdx_t         rob_idx;
      ftqIdx_t         ftq_idx;
      logic            has_mispred;
      logic            branch_taken;
      logic [PC_W-1:0] branch_npc;   // target if taken, fall-through if not
   } branchWBInfo_t;

   typedef struct packed {
      logic            dueToBranch;
      logic            branch_taken;
      logic [PC_W-1:0] arch_pc;
   } squashInfo_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_SQUASH
   } bsq_state_e;

   // a is strictly older than b; equal indices are never older.
   // With differing flags the younger entry has wrapped, so a larger index is older.
   function automatic logic older(input robIdx_t a, input robIdx_t b);
      return (a.flag == b.flag) ? (a.index < b.index) : (a.index > b.index);
   endfunction

endpackage

// File: rtl/branch_squash_ctrl_oldest_sel.sv
// ---------------------------------------------------------------------------
// branch_oldest_sel
// Combinational NUM_BRU-way selection of the oldest mispredicted writeback.
//   i_wb_vld   : per-port writeback valid
//   i_wb_info  : per-port writeback payload
//   o_vld      : at least one valid port reported a mispredict
//   o_info     : payload of the oldest such port (lower port wins a tie)
// ---------------------------------------------------------------------------
module branch_oldest_sel
   import branch_squash_ctrl_pkg::*;
#(
   parameter int unsigned NUM_BRU = 2
) (
   input  logic          [NUM_BRU-1:0] i_wb_vld,
   input  branchWBInfo_t [NUM_BRU-1:0] i_wb_info,
   output logic                        o_vld,
   output branchWBInfo_t               o_info
);

   // Linear scan; a later port replaces the current pick only if strictly
   // older, which is what gives the lower port priority on equal robIdx.
   always_comb begin
      o_vld  = 1'b0;
      o_info = '0;
      for (int unsigned p = 0; p < NUM_BRU; p++) begin
         if (i_wb_vld[p] && i_wb_info[p].has_mispred &&
             (!o_vld || older(i_wb_info[p].rob_idx, o_info.rob_idx))) begin
            o_vld  = 1'b1;
            o_info = i_wb_info[p];
         end
      end
   end

endmodule

// File: rtl/branch_squash_ctrl.sv
// ---------------------------------------------------------------------------
// branch_squash_ctrl
// Holds the oldest in-flight mispredicted branch and, when it retires,
// issues a single one-cycle squash carrying the corrected architectural PC.
//   clk, rst             : core clock, asynchronous active-low reset
//   i_wb_vld/i_wb_info   : branch writebacks from all BRUs
//   i_commit_vld/_rob_idx: retire slots in program order
//   i_flush              : ROB exception/interrupt squash; overrides all
//   o_pending_vld/_rob_idx: currently held mispredict (for commit truncation)
//   o_squash_vld         : one-cycle squash strobe
//   o_squash_info        : squash payload (valid only with o_squash_vld)
//   o_squash_ftq_idx     : FTQ entry of the squashing branch
// ---------------------------------------------------------------------------
module branch_squash_ctrl
   import branch_squash_ctrl_pkg::*;
#(
   parameter int unsigned NUM_BRU      = 2,
   parameter int unsigned COMMIT_WIDTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic          [NUM_BRU-1:0]      i_wb_vld,
   input  branchWBInfo_t [NUM_BRU-1:0]      i_wb_info,
   input  logic          [COMMIT_WIDTH-1:0] i_commit_vld,
   input  robIdx_t       [COMMIT_WIDTH-1:0] i_commit_rob_idx,
   input  logic                             i_flush,
   output logic                             o_pending_vld,
   output robIdx_t                          o_pending_rob_idx,
   output logic                             o_squash_vld,
   output squashInfo_t                      o_squash_info,
   output ftqIdx_t                          o_squash_ftq_idx
);

   bsq_state_e    state_q, state_d;
   branchWBInfo_t held_q, held_d;
   squashInfo_t   sq_info_q, sq_info_d;
   ftqIdx_t       sq_ftq_q, sq_ftq_d;

   logic          cand_vld;
   branchWBInfo_t cand_info;
   logic          cmt_match;

   branch_oldest_sel #(
      .NUM_BRU (NUM_BRU)
   ) u_oldest_sel (
      .i_wb_vld  (i_wb_vld),
      .i_wb_info (i_wb_info),
      .o_vld     (cand_vld),
      .o_info    (cand_info)
   );

   // has_mispred is only ever set in the held copy while it is live,
   // so it doubles as a guard against matching a cleared entry.
   always_comb begin
      cmt_match = 1'b0;
      for (int unsigned s = 0; s < COMMIT_WIDTH; s++) begin
         if (i_commit_vld[s] && (i_commit_rob_idx[s] == held_q.rob_idx)) begin
            cmt_match = 1'b1;
         end
      end
      cmt_match = cmt_match & held_q.has_mispred;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         held_q    <= '0;
         sq_info_q <= '0;
         sq_ftq_q  <= '0;
      end else begin
         state_q   <= state_d;
         held_q    <= held_d;
         sq_info_q <= sq_info_d;
         sq_ftq_q  <= sq_ftq_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      held_d    = held_q;
      sq_info_d = sq_info_q;
      sq_ftq_d  = sq_ftq_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cand_vld) begin
               state_d = ST_HOLD;
               held_d  = cand_info;
            end
         end
         ST_HOLD: begin
            // Retirement of the held branch wins over any writeback this cycle.
            if (cmt_match) begin
               state_d   = ST_SQUASH;
               held_d    = '0;
               sq_info_d = '{dueToBranch  : 1'b1,
                             branch_taken : held_q.branch_taken,
                             arch_pc      : held_q.branch_npc};
               sq_ftq_d  = held_q.ftq_idx;
            end else if (cand_vld && older(cand_info.rob_idx, held_q.rob_idx)) begin
               held_d = cand_info;
            end
         end
         ST_SQUASH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Flush cancels a pending or just-scheduled squash; payload keeps its last value.
      if (i_flush) begin
         state_d   = ST_IDLE;
         held_d    = '0;
         sq_info_d = sq_info_q;
         sq_ftq_d  = sq_ftq_q;
      end
   end

   // Output logic
   always_comb begin
      o_pending_vld     = (state_q == ST_HOLD);
      o_pending_rob_idx = held_q.rob_idx;
      o_squash_vld      = (state_q == ST_SQUASH);
      o_squash_info     = sq_info_q;
      o_squash_ftq_idx  = sq_ftq_q;
   end

endmodule

// File: tb/tb_branch_squash_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_squash_ctrl
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level reference model of the held mispredict.
// ---------------------------------------------------------------------------
module tb_branch_squash_ctrl;
   import branch_squash_ctrl_pkg::*;

   localparam int unsigned NB = 2;
   localparam int unsigned CW = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic          [NB-1:0] wb_vld;
   branchWBInfo_t [NB-1:0] wb_info;
   logic          [CW-1:0] cm_vld;
   robIdx_t       [CW-1:0] cm_idx;
   logic                   flush;

   logic        pend_vld;
   robIdx_t     pend_idx;
   logic        sq_vld;
   squashInfo_t sq_info;
   ftqIdx_t     sq_ftq;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   branch_squash_ctrl #(
      .NUM_BRU      (NB),
      .COMMIT_WIDTH (CW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_wb_vld          (wb_vld),
      .i_wb_info         (wb_info),
      .i_commit_vld      (cm_vld),
      .i_commit_rob_idx  (cm_idx),
      .i_flush           (flush),
      .o_pending_vld     (pend_vld),
      .o_pending_rob_idx (pend_idx),
      .o_squash_vld      (sq_vld),
      .o_squash_info     (sq_info),
      .o_squash_ftq_idx  (sq_ftq)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit            m_held_vld;
   branchWBInfo_t m_held;
   bit            m_sq;
   logic [31:0]   m_pc;
   bit            m_tk;
   ftqIdx_t       m_ftq;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Age as modular ring distance over the 7-bit {flag,index} value.
   function automatic bit m_older(input robIdx_t a, input robIdx_t b);
      logic [6:0] d;
      d = {b.flag, b.index} - {a.flag, a.index};
      return (d != 7'd0) && (d < 7'd64);
   endfunction

   function automatic robIdx_t ri(input logic [6:0] v);
      robIdx_t r;
      r.flag  = v[6];
      r.index = v[5:0];
      return r;
   endfunction

   function automatic branchWBInfo_t mk(input logic [6:0] rob, input logic [31:0] npc,
                                        input bit tk, input logic [4:0] ftq, input bit mp);
      branchWBInfo_t w;
      w.rob_idx      = ri(rob);
      w.ftq_idx      = ftq;
      w.has_mispred  = mp;
      w.branch_taken = tk;
      w.branch_npc   = npc;
      return w;
   endfunction

   task automatic model_reset();
      m_held_vld = 0;
      m_held     = '0;
      m_sq       = 0;
   endtask

   task automatic model_edge();
      branchWBInfo_t q[$];
      branchWBInfo_t c;
      bit cv;
      bit hit;
      bit nsq;
      cv  = 0;
      hit = 0;
      nsq = 0;
      c   = '0;
      for (int p = 0; p < NB; p++)
         if (wb_vld[p] && wb_info[p].has_mispred) q.push_back(wb_info[p]);
      foreach (q[k])
         if (!cv || m_older(q[k].rob_idx, c.rob_idx)) begin c = q[k]; cv = 1; end
      for (int s = 0; s < CW; s++)
         if (cm_vld[s] && cm_idx[s] == m_held.rob_idx) hit = 1;
      if (flush || m_sq) begin
         m_held_vld = 0;
      end else if (m_held_vld && hit) begin
         nsq        = 1;
         m_pc       = m_held.branch_npc;
         m_tk       = m_held.branch_taken;
         m_ftq      = m_held.ftq_idx;
         m_held_vld = 0;
      end else if (cv && (!m_held_vld || m_older(c.rob_idx, m_held.rob_idx))) begin
         m_held     = c;
         m_held_vld = 1;
      end
      m_sq = nsq;
   endtask

   task automatic check_outputs();
      chk("pend_vld", pend_vld, m_held_vld);
      if (m_held_vld) chk("pend_idx", pend_idx, m_held.rob_idx);
      chk("sq_vld", sq_vld, m_sq);
      if (m_sq) begin
         chk("sq_due", sq_info.dueToBranch, 1);
         chk("sq_pc", sq_info.arch_pc, m_pc);
         chk("sq_taken", sq_info.branch_taken, m_tk);
         chk("sq_ftq", sq_ftq, m_ftq);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic clr();
      wb_vld  = '0;
      wb_info = '0;
      cm_vld  = '0;
      cm_idx  = '0;
      flush   = 1'b0;
   endtask

   task automatic put_wb(input int p, input logic [6:0] rob, input logic [31:0] npc, input bit tk);
      wb_vld[p]  = 1'b1;
      wb_info[p] = mk(rob, npc, tk, rob[4:0], 1'b1);
   endtask

   task automatic put_cm(input int s, input logic [6:0] rob);
      cm_vld[s] = 1'b1;
      cm_idx[s] = ri(rob);
   endtask

   initial begin
      logic [6:0] base;
      logic [6:0] v;
      rst = 1'b0;
      clr();
      model_reset();
      #12;
      chk("rst_pend", pend_vld, 0);
      chk("rst_pidx", pend_idx, 0);
      chk("rst_sq", sq_vld, 0);
      chk("rst_info", sq_info, 0);
      chk("rst_ftq", sq_ftq, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // single mispredict
      put_wb(0, 7'd5, 32'h8000_0100, 1);
      step();
      clr();
      repeat (3) step();
      put_cm(2, 7'd5);
      step();
      chk("t1_sq", sq_vld, 1);
      chk("t1_pc", sq_info.arch_pc, 32'h8000_0100);
      clr();
      step();
      chk("t1_idle_sq", sq_vld, 0);
      chk("t1_idle_pend", pend_vld, 0);

      // dual port same cycle
      put_wb(0, 7'd9, 32'h100, 0);
      put_wb(1, 7'd7, 32'h200, 1);
      step();
      chk("t2_held", pend_idx, 7'd7);
      clr(); put_cm(0, 7'd9); step();
      chk("t2_nosq", sq_vld, 0);
      clr(); put_cm(1, 7'd7); step();
      chk("t2_sq", sq_vld, 1);
      chk("t2_pc", sq_info.arch_pc, 32'h200);
      clr(); step();

      // wrap age
      put_wb(0, 7'd62, 32'h300, 0); step();
      clr(); put_wb(0, 7'h41, 32'h304, 1); step();
      chk("t3_keep", pend_idx, 7'd62);
      clr(); flush = 1'b1; step();
      clr(); put_wb(0, 7'h41, 32'h304, 1); step();
      clr(); put_wb(0, 7'd62, 32'h300, 0); step();
      chk("t3_over", pend_idx, 7'd62);
      clr(); flush = 1'b1; step();

      // flush priority over matching commit
      clr(); put_wb(0, 7'd3, 32'h400, 1); step();
      clr(); flush = 1'b1; put_cm(0, 7'd3); step();
      chk("t4_pend", pend_vld, 0);
      chk("t4_sq", sq_vld, 0);
      clr(); step();
      chk("t4_sq2", sq_vld, 0);

      // writebacks discarded in match and squash cycles
      put_wb(0, 7'd20, 32'h500, 0); step();
      clr(); put_cm(3, 7'd20); put_wb(1, 7'd12, 32'h600, 1); step();
      chk("t5_sq", sq_vld, 1);
      clr(); put_wb(0, 7'd12, 32'h600, 1); step();
      chk("t5_pend", pend_vld, 0);
      clr(); step();
      chk("t5_pend2", pend_vld, 0);

      // async reset mid-squash
      put_wb(0, 7'd30, 32'h700, 1); step();
      clr(); put_cm(0, 7'd30); step();
      chk("t6_sq", sq_vld, 1);
      clr();
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_sq", sq_vld, 0);
      chk("t6_rst_pend", pend_vld, 0);
      chk("t6_rst_info", sq_info, 0);
      chk("t6_rst_ftq", sq_ftq, 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      step();

      // randomized traffic
      base = 7'd0;
      repeat (3000) begin
         clr();
         base = base + 7'($urandom_range(0, 3));
         for (int p = 0; p < NB; p++) begin
            if ($urandom_range(0, 2) == 0) begin
               v = base + 7'($urandom_range(0, 40));
               wb_vld[p]  = 1'b1;
               wb_info[p] = mk(v, $urandom, 1'($urandom), 5'($urandom), 1'($urandom));
            end
         end
         for (int s = 0; s < CW; s++) begin
            cm_vld[s] = 1'($urandom);
            cm_idx[s] = ri(base + 7'($urandom_range(0, 40)));
         end
         if (m_held_vld && $urandom_range(0, 3) == 0) begin
            v = 7'($urandom_range(0, CW - 1));
            cm_vld[v[1:0]] = 1'b1;
            cm_idx[v[1:0]] = m_held.rob_idx;
         end
         flush = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/branch_squash_ctrl.md
Name: branch_squash_ctrl

Overview:
- ROB-side consumer of branch writeback (branchWBInfo_t) from all BRUs; producer of squashInfo_t for fetch, FTQ and rename.
- Tracks the single oldest mispredicted branch still in flight.
- When that branch retires, emits exactly one one-cycle squash carrying the corrected architectural PC.
- Exports the pending branch's robIdx so the ROB can truncate a commit group at that branch.

Parameters:
- NUM_BRU, 2, number of branch writeback ports.
- COMMIT_WIDTH, 4, number of ROB retire slots per cycle.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- i_wb_vld  in  NUM_BRU  per-port branch writeback valid.
- i_wb_info  in  branchWBInfo_t[NUM_BRU]  branch writeback payload.
- i_commit_vld  in  COMMIT_WIDTH  retire slot valid, in program order.
- i_commit_rob_idx  in  robIdx_t[COMMIT_WIDTH]  robIdx of each retiring slot.
- i_flush  in  1  ROB exception/interrupt squash this cycle.
- o_pending_vld  out  1  a mispredict is held.
- o_pending_rob_idx  out  robIdx_t  robIdx of the held mispredict.
- o_squash_vld  out  1  one-cycle squash strobe.
- o_squash_info  out  squashInfo_t  squash payload.
- o_squash_ftq_idx  out  ftqIdx_t  FTQ entry of the squashing branch.

Behaviour:
- robIdx_t = {flag, index}; flag toggles on ROB wrap.
- older(a,b) = (a.flag==b.flag) ? (a.index<b.index) : (a.index>b.index). Equal robIdx is never older.
- Reset: all outputs 0; state IDLE; holding register invalid.
- Candidate each cycle: the oldest robIdx among ports with i_wb_vld && has_mispred. Ties are impossible; on tie, the lower port wins.
- States:
  - IDLE: candidate present -> capture it, go to HOLD.
  - HOLD: candidate older than held -> overwrite held (same cycle, registered next edge). If any valid commit slot robIdx == held robIdx -> go to SQUASH, drop held, ignore all writebacks this cycle.
  - SQUASH: o_squash_vld=1 for exactly this cycle, then IDLE. All writebacks ignored in this cycle (they are younger and squashed).
- Squash payload, registered from the held entry:
  - dueToBranch=1.
  - branch_taken = held.branch_taken.
  - arch_pc = held.branch_npc. The BRU writes npc as target if taken, fall-through if not; this block does no PC arithmetic.
  - o_squash_ftq_idx = held.ftq_idx.
- o_pending_vld / o_pending_rob_idx reflect the registered held entry, zero latency from the register. The ROB must not retire slots younger than o_pending_rob_idx in the matching cycle.
- Outputs are stable while o_squash_vld=0: o_squash_info holds its last value and is don't-care.
- i_flush (any state): next state IDLE, held cleared, writebacks that cycle ignored, and a SQUASH scheduled for next cycle is cancelled.
- A squash already being driven (state SQUASH) still completes its cycle.
- Writebacks with has_mispred=0 never change state.
- Reset mid-HOLD/SQUASH: asynchronous return to IDLE; o_squash_vld drops immediately.

Decomposition:
- robIdx_t, ftqIdx_t, branchWBInfo_t, squashInfo_t and an older() age-compare function live in the shared core package/header. older() is reused by the ROB and LSQ.
- One sub-module: branch_oldest_sel, a combinational NUM_BRU-way oldest-mispredict tree. It returns valid plus the winning port payload.

Test Plan:
- Single mispredict: port0 rob {0,5}, npc 0x8000_0100, taken=1. Commit slot2 rob {0,5} three cycles later -> o_squash_vld high exactly 1 cycle after the commit cycle, arch_pc 0x8000_0100, dueToBranch=1, state back to IDLE.
- Dual-port same cycle: port0 rob {0,9}, port1 rob {0,7} -> held {0,7}. Commit of {0,9} alone produces no squash; commit of {0,7} produces the squash.
- Wrap age: held {0,62} with ROB size 64, then port0 delivers {1,1} -> held unchanged. Held {1,1}, then {0,62} arrives -> overwritten with {0,62}.
- Flush priority: held {0,3}; i_flush and a matching commit {0,3} in the same cycle -> no squash, o_pending_vld=0 next cycle.
- Squash-cycle discard: a mispredict writeback {0,12} arriving during the match cycle and during the SQUASH cycle -> state IDLE afterwards, o_pending_vld=0.
- Async reset: assert rst low mid-SQUASH -> o_squash_vld=0 before the next clk edge, with all outputs zero.
